b09_serial_tx: RTL and testbench

- Serial frame transmitter that drives the `x` input of the b09 serial converter.
- Accepts 8-bit parallel words over a valid/ready handshake.
- Emits each word as a 9-bit frame on a single line: marker bit `1`, then 8 data bits LSB first, then a programmable run of zeros. The zero run gives the converter time to finish its EXECUTE/LOAD_OLD phases.
- Sits in the converter test harness ahead of the converter.

---
 rtl/b09_serial_tx_pkg.sv | 23 ++
 rtl/b09_serial_tx.sv | 95 +++++++++
 tb/tb_b09_serial_tx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/b09_serial_tx_pkg.sv
// Shared definitions for the b09 serial frame transmitter and the converter-side model.
package b09_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_GAP
  } state_t;

  localparam int unsigned DATA_W_C   = 8;
  localparam logic        MARKER_BIT = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/b09_serial_tx.sv
// Serial frame transmitter: marker bit, DATA_W data bits LSB first, then GAP zero cycles.
module b09_serial_tx
  import b09_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_C,
  parameter int unsigned GAP    = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              x_out,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frames_sent
);

  localparam int unsigned       BIT_W    = (clog2(DATA_W) > 0) ? clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [3:0]        GAP_LAST = 4'(GAP - 1);
  // GAP_PRE wraps to 15 when GAP==1; gap_cnt never reaches it, that case is handled on GAP entry.
  localparam logic [3:0]        GAP_PRE  = 4'(GAP - 2);
  localparam logic              GAP_ONE  = (GAP == 1);

  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [BIT_W-1:0]    bit_cnt;
  logic [3:0]          gap_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      x_out       <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frames_sent <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
            state    <= ST_START;
            x_out    <= MARKER_BIT;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_START: begin
          state   <= ST_DATA;
          bit_cnt <= '0;
          x_out   <= shreg[0];
          shreg   <= shreg >> 1;
        end
        ST_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
            x_out   <= 1'b0;
            if (GAP_ONE) begin
              frame_done  <= 1'b1;
              frames_sent <= frames_sent + 1'b1;
            end
          end else begin
            x_out   <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= ST_IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            // Outputs are registered, so the pulse is launched one edge before the last gap cycle.
            if (gap_cnt == GAP_PRE) begin
              frame_done  <= 1'b1;
              frames_sent <= frames_sent + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_b09_serial_tx.sv
// Scoreboard bench for b09_serial_tx: expected words queued at issue, frames decoded from x_out.
module tb_b09_serial_tx;

  localparam int unsigned GAP = 3;

  logic       clock;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       x_out;
  logic       busy;
  logic       frame_done;
  logic [7:0] frames_sent;

  b09_serial_tx #(.DATA_W(8), .GAP(GAP), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .x_out       (x_out),
    .busy        (busy),
    .frame_done  (frame_done),
    .frames_sent (frames_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  logic [7:0] sb_q[$];
  int         phase      = 0;
  int         exp_sent   = 0;
  int         last_mark  = 0;
  int         mark_gap   = 0;
  bit         chk_ready  = 0;
  logic [7:0] rx;
  logic [7:0] conv_old   = '0;
  logic       conv_match = 1'b0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decodes frames from the serial line and checks them against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      phase     = 0;
      exp_sent  = 0;
      chk_ready = 0;
    end else begin
      if (chk_ready) begin
        chk("tx_ready_after_gap", {31'd0, tx_ready}, 32'd1);
        chk_ready = 0;
      end
      if (phase == 0) begin
        if (x_out) begin
          chk("busy_in_frame", {31'd0, busy}, 32'd1);
          mark_gap  = cyc - last_mark;
          last_mark = cyc;
          phase     = 1;
        end
      end else if (phase <= 8) begin
        rx[phase-1] = x_out;
        if (phase == 8) begin
          if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got %0h expected no frame (cycle %0d)", rx, cyc);
          end else begin
            chk("frame_data", {24'd0, rx}, {24'd0, sb_q.pop_front()});
          end
          conv_match = (rx == conv_old);
          conv_old   = rx;
        end
        phase++;
      end else begin
        chk("gap_zero", {31'd0, x_out}, 32'd0);
        chk("frame_done", {31'd0, frame_done}, {31'd0, (phase - 9) == int'(GAP) - 1});
        if ((phase - 9) == int'(GAP) - 1) begin
          exp_sent = (exp_sent + 1) % 256;
          chk("frames_sent", {24'd0, frames_sent}, 32'(exp_sent));
          phase     = 0;
          chk_ready = 1;
        end else begin
          phase++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit hold, input bit expect_frame);
    bit ok;
    tx_data  = d;
    tx_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (tx_ready) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      tx_valid = 1'b0;
      return;
    end
    if (expect_frame) sb_q.push_back(d);
    @(posedge clock);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      #1;
      if (sb_q.size() == 0 && phase == 0 && !chk_ready) begin
        ok = 1;
        break;
      end
    end
    chk("drain", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_x_out", {31'd0, x_out}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_frames_sent", {24'd0, frames_sent}, 32'd0);
    reset = 1'b0;

    send(8'hA5, 0, 1);
    drain();

    send(8'h00, 1, 1);
    send(8'hFF, 0, 1);
    drain();
    chk("b2b_spacing", 32'(mark_gap), 32'd13);
    chk("b2b_frames_sent", {24'd0, frames_sent}, 32'd3);

    send(8'h3C, 0, 1);
    send(8'h3C, 0, 1);
    drain();
    chk("conv_old", {24'd0, conv_old}, 32'h3C);
    chk("conv_match", {31'd0, conv_match}, 32'd1);

    // Reset during data bit 4 of 0x81: the partial frame is abandoned.
    send(8'h81, 0, 0);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("midrst_x_out", {31'd0, x_out}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("midrst_frames_sent", {24'd0, frames_sent}, 32'd0);
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    send(8'h01, 0, 1);
    drain();

    // Inputs toggle while the frame is in flight; none of it may be accepted.
    send(8'h5A, 0, 1);
    for (int i = 0; i < 11; i++) begin
      @(posedge clock);
      #1;
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
    end
    tx_valid = 1'b0;
    drain();
    chk("toggle_frames_sent", {24'd0, frames_sent}, 32'd2);

    reset = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) send(8'(i), 0, 1);
    drain();
    chk("wrap_frames_sent", {24'd0, frames_sent}, 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
